multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).
//  Drives PC/IR/register-file/memory enables and the mux selects each cycle.
//  Waits on a memory ready handshake.
//  Sits beside the datapath; replaces the single-cycle control unit in the multicycle core.
// PARAMETERS
//  none (state and opcode encodings are fixed constants in the shared package)
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  op          in   7  opcode from instruction register
//  func3       in   3  funct3 from instruction register
//  func7       in   1  funct7[5] from instruction register
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory has completed the current read/write this cycle
//  PCWrite     out  1  PC load enable = PCUpdate | (Branch & zero)
//  AdrSrc      out  1  memory address select: 0 = PC, 1 = ALUOut
//  MemWrite    out  1  data memory write enable
//  IRWrite     out  1  instruction register (and OldPC) load enable
//  RegWrite    out  1  register file write enable
//  ResultSrc   out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
//  ALUSrcA     out  2  00 = PC, 01 = OldPC, 10 = RD1
//  ALUSrcB     out  2  00 = RD2, 01 = ImmExt, 10 = const 4
//  ImmSrc      out  2  decoded from op in every state: I=00, S=01, B=10, J=11; other ops = 00
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  instr_done  out  1  1-cycle pulse in the final state of each legal instruction
//  illegal_op  out  1  1-cycle pulse in DECODE when op is unsupported
// BEHAVIOUR
//  Reset: state <= FETCH asynchronously.
//   While rst_n = 0, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_op are forced to 0.
//   Selects take their FETCH values.
//   Reset asserted mid-instruction abandons it; no write enable fires after reset assertion.
//  States and outputs (unlisted enables are 0; ALUOp: 00 add, 01 sub, 10 per funct):
//   FETCH    AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//            IRWrite = PCUpdate = mem_ready.
//            Stays in FETCH until mem_ready = 1, then goes to DECODE.
//   DECODE   ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
//            lw/sw -> MEMADR; R -> EXECR; I -> EXECI; beq -> BEQ; jal -> JAL.
//            Any other op: illegal_op = 1, next state FETCH, no architectural write.
//   MEMADR   ALUSrcA=10, ALUSrcB=01, ALUOp=00.
//            lw (op[5] = 0) -> MEMREAD; sw -> MEMWR.
//   MEMREAD  AdrSrc=1, ResultSrc=00. Holds until mem_ready = 1, then goes to MEMWB.
//   MEMWB    ResultSrc=01, RegWrite=1, instr_done=1. Next state FETCH.
//   MEMWR    AdrSrc=1, ResultSrc=00, MemWrite=1 while waiting.
//            Holds until mem_ready = 1; instr_done = mem_ready. Next state FETCH.
//   EXECR    ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
//   EXECI    ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
//   JAL      ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
//   ALUWB    ResultSrc=00, RegWrite=1, instr_done=1. Next state FETCH.
//   BEQ      ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
//            func3 is ignored. Next state FETCH.
//  Latency with mem_ready tied to 1: beq 3; sw, R, I, jal 4; lw 5 cycles.
//   Each wait cycle on mem_ready adds one cycle.
//  mem_ready outside FETCH, MEMREAD and MEMWR is ignored.
//  State register is the only storage. All outputs are combinational from state, op, func3, func7, zero, mem_ready.
//   No output depends on a same-cycle write enable.
//  Unreachable state encodings recover to FETCH on the next edge, with all enables 0.
// STRUCTURE
//  Shared package (riscv_pkg): state encodings, opcode constants, ALUOp codes, ALUControl codes,
//   ImmSrc/ResultSrc/ALUSrc select codes.
//  Sub-module: instantiate the existing alu_decoder (ALUOp, func3, op5 = op[5], func7_5 -> ALUControl).
//  The FSM (next-state and output logic) stays in this file.
// TESTING
//  1. Hold rst_n = 0, then release with mem_ready = 1, op = lw (0000011).
//     -> States FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
//     -> RegWrite = 1 and ResultSrc = 01 only in cycle 5; instr_done in cycle 5.
//  2. R-type sub (op 0110011, func3 000, func7 1).
//     -> EXECR drives ALUControl = 001; ALUWB RegWrite = 1; 4 cycles total.
//  3. beq with zero = 1, then with zero = 0.
//     -> PCWrite = 1 in the BEQ cycle only when zero = 1; 3 cycles each.
//  4. sw with mem_ready low for 3 cycles in MEMWR.
//     -> MemWrite held 4 cycles; instr_done only in the ready cycle.
//     -> FETCH waiting with mem_ready = 0 keeps IRWrite = PCWrite = 0.
//  5. jal (1101111).
//     -> JAL state has PCWrite = 1, ImmSrc = 11; ALUWB writes with ResultSrc = 00.
//  6. op = 1111111 -> illegal_op pulse in DECODE, back in FETCH, no RegWrite/MemWrite.
//     Also: drop rst_n in MEMREAD -> FETCH immediately, all enables 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, opcodes,
// ALU operation/control codes and datapath mux select codes.
package riscv_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned ALUC_W = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ST_W   = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_JAL     = 4'd8,
    S_ALUWB   = 4'd9,
    S_BEQ     = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [SEL_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction funct fields onto the
// ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t           alu_op,
  input  logic [F3_W-1:0]   func3,
  input  logic              op5,
  input  logic              func7_5,
  output logic [ALUC_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          // sub only for R-type; addi's imm[10] lands in func7_5
          3'b000:  alu_control = (op5 & func7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I-subset datapath; outputs are
// combinational from state and instruction fields, enables gated by reset.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op,
  input  logic [F3_W-1:0]   func3,
  input  logic              func7,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic [SEL_W-1:0]  ResultSrc,
  output logic [SEL_W-1:0]  ALUSrcA,
  output logic [SEL_W-1:0]  ALUSrcB,
  output logic [SEL_W-1:0]  ImmSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              instr_done,
  output logic              illegal_op
);

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    pc_update, branch, ir_write, reg_write, mem_write, done, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = ADR_PC;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;

    case (state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = ADR_ALUOUT;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc     = ADR_ALUOUT;
        mem_write  = 1'b1;
        done       = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        done    = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset suppresses every architectural write and status pulse
    PCWrite    = rst_n & (pc_update | (branch & zero));
    IRWrite    = rst_n & ir_write;
    RegWrite   = rst_n & reg_write;
    MemWrite   = rst_n & mem_write;
    instr_done = rst_n & done;
    illegal_op = rst_n & illegal;
  end

  assign ImmSrc = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .func3       (func3),
    .op5         (op[5]),
    .func7_5     (func7),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed instruction table plus random instruction
// streams, compared cycle by cycle against per-instruction cycle sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7, zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_e;

  // One clock of expected behaviour; care = {adr, res, srca, srcb, aluc}
  typedef struct {
    logic       mr, z;
    logic       pcw, adr, mw, irw, rw, done, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] aluc;
    logic [4:0] care;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         fw, mw;
    logic       zb;
    logic [2:0] aluc;
    int         lat;
  } dir_t;

  cyc_t       q[$];
  dir_t       dt[13];
  int         n_vec = 0;
  int         n_err = 0;
  logic [17:0] outv;

  assign outv = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, ALUControl, instr_done, illegal_op};

  function automatic kind_e classify(input logic [6:0] o);
    if (o == LW)  return K_LW;
    if (o == SW)  return K_SW;
    if (o == RT)  return K_R;
    if (o == IT)  return K_I;
    if (o == BEQ) return K_BEQ;
    if (o == JAL) return K_JAL;
    return K_ILL;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == RT && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic int lat_ref(input kind_e k, input int fw, input int mw);
    int base;
    case (k)
      K_LW:    base = 5;
      K_BEQ:   base = 3;
      K_ILL:   base = 2;
      default: base = 4;
    endcase
    return base + fw + ((k == K_LW || k == K_SW) ? mw : 0);
  endfunction

  function automatic cyc_t blank(input logic [6:0] o);
    cyc_t c;
    c.mr = 1'($urandom); c.z = 1'($urandom);
    {c.pcw, c.adr, c.mw, c.irw, c.rw, c.done, c.ill} = '0;
    c.res = '0; c.sa = '0; c.sb = '0; c.aluc = '0; c.care = '0;
    c.imm = imm_ref(o);
    return c;
  endfunction

  function automatic cyc_t fetch_cyc(input logic [6:0] o, input logic mr);
    cyc_t c;
    c = blank(o);
    c.mr = mr; c.irw = mr; c.pcw = mr;
    c.adr = 1'b0; c.res = 2'b10; c.sa = 2'b00; c.sb = 2'b10; c.aluc = 3'b000;
    c.care = 5'b11111;
    return c;
  endfunction

  function automatic logic [17:0] pack_exp(input cyc_t c);
    return {c.pcw, c.adr, c.mw, c.irw, c.rw, c.res, c.sa, c.sb, c.imm, c.aluc, c.done, c.ill};
  endfunction

  function automatic logic [17:0] pack_msk(input cyc_t c);
    return {1'b1, c.care[4], 3'b111, {2{c.care[3]}}, {2{c.care[2]}}, {2{c.care[1]}},
            2'b11, {3{c.care[0]}}, 2'b11};
  endfunction

  // Expected cycle sequence of one instruction, with bench-chosen memory stalls
  task automatic gen_instr(input logic [6:0] o, input int fw, input int mw,
                           input logic zb, input logic [2:0] exec_aluc);
    kind_e k;
    cyc_t  c;
    k = classify(o);
    for (int i = 0; i < fw; i++) q.push_back(fetch_cyc(o, 1'b0));
    q.push_back(fetch_cyc(o, 1'b1));
    c = blank(o); c.sa = 2'b01; c.sb = 2'b01; c.care = 5'b00111; c.ill = (k == K_ILL);
    q.push_back(c);
    case (k)
      K_LW, K_SW: begin
        c = blank(o); c.sa = 2'b10; c.sb = 2'b01; c.care = 5'b00111;
        q.push_back(c);
        for (int i = 0; i <= mw; i++) begin
          c = blank(o); c.mr = (i == mw); c.adr = 1'b1; c.care = 5'b11000;
          c.mw = (k == K_SW); c.done = (k == K_SW) && (i == mw);
          q.push_back(c);
        end
        if (k == K_LW) begin
          c = blank(o); c.res = 2'b01; c.rw = 1'b1; c.done = 1'b1; c.care = 5'b01000;
          q.push_back(c);
        end
      end
      K_R, K_I, K_JAL: begin
        c = blank(o);
        if (k == K_JAL) begin
          c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; c.care = 5'b01111;
        end else begin
          c.sa = 2'b10; c.sb = (k == K_R) ? 2'b00 : 2'b01; c.aluc = exec_aluc; c.care = 5'b00111;
        end
        q.push_back(c);
        c = blank(o); c.rw = 1'b1; c.done = 1'b1; c.care = 5'b01000;
        q.push_back(c);
      end
      K_BEQ: begin
        c = blank(o); c.z = zb; c.pcw = zb; c.done = 1'b1;
        c.sa = 2'b10; c.sb = 2'b00; c.aluc = 3'b001; c.care = 5'b01111;
        q.push_back(c);
      end
      default: ;
    endcase
  endtask

  task automatic run_cycle(input cyc_t c, input int idx, output logic seen);
    logic [17:0] e, m;
    mem_ready = c.mr;
    zero      = c.z;
    @(negedge clk);
    e = pack_exp(c);
    m = pack_msk(c);
    n_vec++;
    if ((outv & m) !== (e & m)) begin
      n_err++;
      $display("FAIL outputs op=%b cycle=%0d: got %h expected %h (mask %h)",
               op, idx, outv & m, e & m, m);
    end
    seen = instr_done | illegal_op;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, input logic zb,
                           input logic [2:0] exec_aluc, input int exp_lat);
    int   lat;
    logic seen;
    q.delete();
    gen_instr(o, fw, mw, zb, exec_aluc);
    op = o; func3 = f3; func7 = f7;
    lat = 0;
    for (int i = 0; i < q.size(); i++) begin
      run_cycle(q[i], i, seen);
      if (seen && lat == 0) lat = i + 1;
    end
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL latency op=%b: got %0d expected %0d", o, lat, exp_lat);
    end
  endtask

  initial begin
    cyc_t       c;
    logic       seen;
    logic [6:0] ro;
    logic [2:0] rf3;
    logic       rf7;
    int         fw, mw;

    dt[0]  = '{LW,  3'b010, 1'b0, 0, 0, 1'b0, 3'b000, 5};
    dt[1]  = '{RT,  3'b000, 1'b1, 0, 0, 1'b0, 3'b001, 4};
    dt[2]  = '{BEQ, 3'b000, 1'b0, 0, 0, 1'b1, 3'b000, 3};
    dt[3]  = '{BEQ, 3'b000, 1'b0, 0, 0, 1'b0, 3'b000, 3};
    dt[4]  = '{SW,  3'b010, 1'b0, 2, 3, 1'b0, 3'b000, 9};
    dt[5]  = '{JAL, 3'b000, 1'b0, 0, 0, 1'b0, 3'b000, 4};
    dt[6]  = '{7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 3'b000, 2};
    dt[7]  = '{RT,  3'b000, 1'b0, 0, 0, 1'b0, 3'b000, 4};
    dt[8]  = '{RT,  3'b110, 1'b0, 0, 0, 1'b0, 3'b011, 4};
    dt[9]  = '{RT,  3'b111, 1'b0, 1, 0, 1'b0, 3'b010, 5};
    dt[10] = '{RT,  3'b010, 1'b0, 0, 0, 1'b0, 3'b101, 4};
    dt[11] = '{IT,  3'b000, 1'b1, 0, 0, 1'b0, 3'b000, 4};
    dt[12] = '{LW,  3'b010, 1'b0, 1, 2, 1'b0, 3'b000, 8};

    // Reset held with ready and a taken-branch opcode: nothing may fire
    rst_n = 1'b0; op = LW; func3 = '0; func7 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    c = fetch_cyc(LW, 1'b1); c.irw = 1'b0; c.pcw = 1'b0;
    run_cycle(c, 0, seen);
    op = BEQ;
    c = fetch_cyc(BEQ, 1'b1); c.irw = 1'b0; c.pcw = 1'b0; c.z = 1'b1;
    run_cycle(c, 0, seen);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_instr(dt[i].op, dt[i].f3, dt[i].f7, dt[i].fw, dt[i].mw, dt[i].zb,
                dt[i].aluc, dt[i].lat);

    // Reset dropped while a load waits in MEMREAD
    q.delete();
    gen_instr(LW, 0, 3, 1'b0, 3'b000);
    op = LW; func3 = 3'b010; func7 = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle(q[i], i, seen);
    #1 rst_n = 1'b0;
    c = fetch_cyc(LW, 1'b1); c.irw = 1'b0; c.pcw = 1'b0;
    run_cycle(c, 0, seen);
    rst_n = 1'b1;
    run_instr(RT, 3'b000, 1'b1, 0, 0, 1'b0, 3'b001, 4);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: ro = LW;
        1: ro = SW;
        2: ro = RT;
        3: ro = IT;
        4: ro = BEQ;
        5: ro = JAL;
        default: ro = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      rf7 = 1'($urandom);
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 3);
      run_instr(ro, rf3, rf7, fw, mw, 1'($urandom), alu_ref(ro, rf3, rf7),
                lat_ref(classify(ro), fw, mw));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
